pipe_reg: RTL



---
 rtl/pipe_reg_pkg.sv | 26 ++
 rtl/pipe_reg_if.sv | 35 +++
 rtl/pipe_reg_stage.sv | 45 ++++
 rtl/pipe_reg.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pipe_reg_pkg.sv
// Shared types and sizing helpers for pipe_reg and neighbouring softmax datapath blocks.
package pipe_reg_pkg;

  localparam int unsigned MAX_STAGES         = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  // Handshake beat as exchanged between softmax units (exp, accumulate, divide).
  typedef struct packed {
    logic                          valid;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } pipe_beat_t;

  // Occupancy counter width; sized so capacity STAGES+1 (skid build) always fits.
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 2);
  endfunction

  function automatic pipe_beat_t make_beat(input logic valid,
                                           input logic [DEFAULT_DATA_WIDTH-1:0] data);
    pipe_beat_t beat;
    beat.valid = valid;
    beat.data  = data;
    return beat;
  endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// Valid/ready handshake bundle for both sides of pipe_reg.
interface pipe_reg_if
  import pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  // Surrounding logic: drives the upstream beat and the downstream ready.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // The pipeline register itself.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pipe_reg_stage.sv
// One elastic stage: a valid flop plus a data word that only changes on a valid load.
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_load,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_data_en;

  // Data is frozen on flush too, so an emptied stage still shows its last word.
  assign w_data_en = i_load && i_valid && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_data_en) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_reg.sv
// Elastic valid/ready pipeline register with bubble collapsing, flush and occupancy count.
// Optional PIPE_REG_SKID_EN adds a skid entry so the ready chain depends only on flops.
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned STAGES     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  pipe_reg_if.slave                      bus,
  output logic [occ_width(STAGES)-1:0]   occupancy
);

  localparam int unsigned OCC_W = occ_width(STAGES);
  localparam int unsigned LAST  = STAGES - 1;

  if ((STAGES < 1) || (STAGES > MAX_STAGES)) begin : g_bad_stages
    $error("pipe_reg: STAGES must be within 1..16");
  end

  logic [STAGES:0]       w_ready;
  logic                  w_tail_ready;
  logic [STAGES-1:0]     w_valid;
  logic [STAGES-1:0]     w_stg_in_valid;
  logic [DATA_WIDTH-1:0] w_data         [STAGES];
  logic [DATA_WIDTH-1:0] w_stg_in_data  [STAGES];
  logic                  w_accept;
  logic                  w_emit;
  logic [OCC_W-1:0]      r_occ;

  // Backward ready chain: an empty stage always accepts, so bubbles collapse.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = w_tail_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      w_ready[i] = !w_valid[i] || w_ready[i+1];
    end
  end

  always_comb begin
    w_stg_in_valid = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      w_stg_in_data[i] = '0;
    end
    w_stg_in_valid[0] = bus.in_valid;
    w_stg_in_data[0]  = bus.in_data;
    for (int i = 1; i < int'(STAGES); i++) begin
      w_stg_in_valid[i] = w_valid[i-1];
      w_stg_in_data[i]  = w_data[i-1];
    end
  end

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
    pipe_reg_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_load  (w_ready[g]),
      .i_valid (w_stg_in_valid[g]),
      .i_data  (w_stg_in_data[g]),
      .o_valid (w_valid[g]),
      .o_data  (w_data[g])
    );
  end

`ifdef PIPE_REG_SKID_EN
  logic                  w_skid_valid;
  logic [DATA_WIDTH-1:0] w_skid_data;
  logic                  w_skid_load;
  logic                  w_skid_in_valid;

  // Last stage always advances while skid is empty; a beat that cannot leave is parked.
  assign w_tail_ready    = !w_skid_valid;
  assign w_skid_load     = !w_skid_valid || bus.out_ready;
  assign w_skid_in_valid = !w_skid_valid && w_valid[LAST] && !bus.out_ready;

  pipe_reg_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_load  (w_skid_load),
    .i_valid (w_skid_in_valid),
    .i_data  (w_data[LAST]),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  // Skid holds the older beat, so it drains ahead of the last stage.
  assign bus.out_valid = w_skid_valid || w_valid[LAST];
  assign bus.out_data  = w_skid_valid ? w_skid_data : w_data[LAST];
`else
  assign w_tail_ready  = bus.out_ready;
  assign bus.out_valid = w_valid[LAST];
  assign bus.out_data  = w_data[LAST];
`endif

  assign bus.in_ready = w_ready[0] && !flush;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_emit       = bus.out_valid && bus.out_ready;

  // Beat count; bounded by the handshakes themselves, so no saturation logic is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_accept && !w_emit) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_accept && w_emit) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign occupancy = r_occ;

endmodule
